operand_stage: RTL

Decode-to-execute stage that sits directly upstream of the ALU. It holds the 32-entry architectural register file (X31 reads as zero) and applies write-back bypass. It sign/zero-extends the instruction immediate, selects ALU operand 2 from register or immediate, and presents everything to the ALU through a one-deep valid/ready pipeline register. The register is refreshed by late write-backs while stalled.

---
 rtl/operand_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register file with write-back bypass,
// immediate extension and a one-deep valid/ready register in front of the ALU.
module operand_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rd_reg1,
  input  logic [REG_AW-1:0] rd_reg2,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] imm_raw,
  input  logic [1:0]        imm_kind,
  input  logic [3:0]        opcode_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] offset_out,
  output logic [3:0]        opcode_out
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(NUM_REGS - 1);

  logic [DATA_W-1:0] regFile [NUM_REGS];
  logic              wbWrite;
  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] srcB;
  logic [DATA_W-1:0] immExt;
  logic              capture;
  logic              unusedImmHigh;

  logic              outValidQ, outValidD;
  logic [DATA_W-1:0] op1Q, op1D;
  logic [DATA_W-1:0] op2Q, op2D;
  logic [DATA_W-1:0] storeQ, storeD;
  logic [DATA_W-1:0] offsetQ, offsetD;
  logic [3:0]        opcodeQ, opcodeD;
  logic [REG_AW-1:0] idx1Q, idx1D;
  logic [REG_AW-1:0] idx2Q, idx2D;
  logic              aluSrcQ, aluSrcD;

  assign wbWrite       = wb_en && (wb_reg != ZERO_IDX);
  assign unusedImmHigh = ^imm_raw[DATA_W-1:26];

  // Architectural register file; the zero register is never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regFile[i] <= '0;
      end
    end else if (wbWrite) begin
      regFile[wb_reg] <= wb_data;
    end
  end

  // Source reads with same-cycle write-back bypass.
  always_comb begin
    srcA = regFile[rd_reg1];
    srcB = regFile[rd_reg2];
    if (rd_reg1 == ZERO_IDX) begin
      srcA = '0;
    end else if (wbWrite && (wb_reg == rd_reg1)) begin
      srcA = wb_data;
    end
    if (rd_reg2 == ZERO_IDX) begin
      srcB = '0;
    end else if (wbWrite && (wb_reg == rd_reg2)) begin
      srcB = wb_data;
    end
  end

  always_comb begin
    immExt = '0;
    case (imm_kind)
      2'b00:   immExt = {{(DATA_W-12){1'b0}}, imm_raw[11:0]};
      2'b01:   immExt = {{(DATA_W-9){imm_raw[8]}}, imm_raw[8:0]};
      2'b10:   immExt = {{(DATA_W-19){imm_raw[18]}}, imm_raw[18:0]};
      default: immExt = {{(DATA_W-26){imm_raw[25]}}, imm_raw[25:0]};
    endcase
  end

  assign in_ready = !flush && (!outValidQ || out_ready);
  assign capture  = in_valid && in_ready;

  // Pipeline register next state: flush > capture > drain > stall refresh.
  always_comb begin
    outValidD = outValidQ;
    op1D      = op1Q;
    op2D      = op2Q;
    storeD    = storeQ;
    offsetD   = offsetQ;
    opcodeD   = opcodeQ;
    idx1D     = idx1Q;
    idx2D     = idx2Q;
    aluSrcD   = aluSrcQ;
    if (flush) begin
      outValidD = 1'b0;
    end else if (capture) begin
      outValidD = 1'b1;
      op1D      = srcA;
      op2D      = alu_src ? immExt : srcB;
      storeD    = srcB;
      offsetD   = immExt;
      opcodeD   = opcode_in;
      idx1D     = rd_reg1;
      idx2D     = rd_reg2;
      aluSrcD   = alu_src;
    end else if (outValidQ && out_ready) begin
      outValidD = 1'b0;
    end else if (outValidQ) begin
      // Late write-back landing on a stalled instruction's sources.
      if (wbWrite && (wb_reg == idx1Q)) begin
        op1D = wb_data;
      end
      if (wbWrite && (wb_reg == idx2Q)) begin
        storeD = wb_data;
        if (!aluSrcQ) begin
          op2D = wb_data;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outValidQ <= 1'b0;
      op1Q      <= '0;
      op2Q      <= '0;
      storeQ    <= '0;
      offsetQ   <= '0;
      opcodeQ   <= '0;
      idx1Q     <= '0;
      idx2Q     <= '0;
      aluSrcQ   <= 1'b0;
    end else begin
      outValidQ <= outValidD;
      op1Q      <= op1D;
      op2Q      <= op2D;
      storeQ    <= storeD;
      offsetQ   <= offsetD;
      opcodeQ   <= opcodeD;
      idx1Q     <= idx1D;
      idx2Q     <= idx2D;
      aluSrcQ   <= aluSrcD;
    end
  end

  assign out_valid  = outValidQ;
  assign operand1   = op1Q;
  assign operand2   = op2Q;
  assign store_data = storeQ;
  assign offset_out = offsetQ;
  assign opcode_out = opcodeQ;

endmodule
